inst_encoder: RTL

Instruction encoder and program writer: accepts decoded instruction fields plus a full 32-bit immediate over a valid/ready handshake. It range-checks the immediate, packs it into the RV32I I/S/B/U/J bit layout, and writes the resulting word into instruction memory at an auto-incrementing word address. It is the inverse of the immediate extension path and sits between the self-test/program-load controller and the instruction memory write port.

---
 rtl/inst_encoder_pkg.sv | 26 ++
 rtl/inst_encoder_pack.sv | 65 ++++++
 rtl/inst_encoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared types for the instruction encoder: immediate format codes, error codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_encoder_pkg;

    // Same encoding as the decoder's immediate-control field.
    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } imm_fmt_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_t;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I packer: checks the immediate and places it in I/S/B/U/J bit layout.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: i_fmt/i_opcode/i_rd/i_rs1/i_rs2/i_funct3/i_imm in; o_word packed word, o_err flag, o_err_code.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    // A value fits an N-bit signed field when all bits from N-1 upward equal the sign.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    // Misalignment outranks range, illegal type outranks both.
    always_comb begin
        o_word     = '0;
        o_err_code = ERR_NONE;
        case (i_fmt)
            FMT_I: begin
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                if (!w_fit12) o_err_code = ERR_RANGE;
            end
            FMT_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                if (!w_fit12) o_err_code = ERR_RANGE;
            end
            FMT_B: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                if (i_imm[0])      o_err_code = ERR_MISALIGN;
                else if (!w_fit13) o_err_code = ERR_RANGE;
            end
            FMT_U: begin
                o_word = {i_imm[31:12], i_rd, i_opcode};
                if (|i_imm[11:0]) o_err_code = ERR_MISALIGN;
            end
            FMT_J: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                if (i_imm[0])      o_err_code = ERR_MISALIGN;
                else if (!w_fit21) o_err_code = ERR_RANGE;
            end
            default: begin
                o_err_code = ERR_ILLEGAL;
            end
        endcase
    end

    assign o_err = (o_err_code != ERR_NONE);

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder/program writer: packs field bundles into RV32I words and writes them to imem.
// Latency: handshake at edge k -> mem_we from cycle k+1; one word per 2 cycles peak; errors pulse at k+1.
// Backpressure: in_ready low outside IDLE; mem_ready low holds mem_we/mem_addr/mem_wdata indefinitely.
// Ports: clk/rst/clear; in_* bundle with in_valid/in_ready; mem_we/mem_ready/mem_addr/mem_wdata;
//        err_valid/err_code; count (words written), full (address space exhausted).
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] L_LAST = '1;

    enc_state_t        r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_err_valid;
    logic [1:0]        r_err_code;
    logic [ADDR_W:0]   r_count;
    logic              r_full;

    logic [31:0]       w_word;
    logic              w_err;
    logic [1:0]        w_err_code;
    logic              w_hs;
    logic              w_unused;

    // funct7 only matters for R-type, which this encoder does not emit.
    assign w_unused = ^in_funct7;

    inst_pack u_pack (
        .i_fmt      (in_type),
        .i_opcode   (in_opcode),
        .i_rd       (in_rd),
        .i_rs1      (in_rs1),
        .i_rs2      (in_rs2),
        .i_funct3   (in_funct3),
        .i_imm      (in_imm),
        .o_word     (w_word),
        .o_err      (w_err),
        .o_err_code (w_err_code)
    );

    // Depends only on state and clear so upstream may gate in_valid on it without a loop.
    assign in_ready = (r_state == ST_IDLE) & ~clear;
    assign w_hs     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= L_BASE;
            r_mem_wdata <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_count     <= '0;
            r_full      <= 1'b0;
        end else if (clear) begin
            // Abandons any pending write, even one the memory would accept this cycle.
            r_state     <= ST_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= L_BASE;
            r_err_valid <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        if (w_err) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= w_err_code;
                        end else begin
                            r_mem_wdata <= w_word;
                            r_mem_we    <= 1'b1;
                            r_state     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        r_mem_we <= 1'b0;
                        r_count  <= r_count + 1'b1;
                        // Last address: stay on it and lock up until clear/rst.
                        if (r_mem_addr == L_LAST) begin
                            r_full  <= 1'b1;
                            r_state <= ST_FULL;
                        end else begin
                            r_mem_addr <= r_mem_addr + 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    r_state <= ST_FULL;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign count     = r_count;
    assign full      = r_full;

endmodule
